ram_b_ctrl: RTL and testbench

- CPU-side bus controller directly upstream of the 128x32 block RAM.
- Accepts word/byte-enable requests from the CPU data bus; drives the RAM's word address, write enable and write data; captures the RAM's 1-cycle-latency read data.
- Returns a one-cycle response pulse.
- Implements read-modify-write for partial writes and flags out-of-range addresses as a bus error.

---
 rtl/ram_b_ctrl_pkg.sv | 19 +
 rtl/ram_b_ctrl_be_merge.sv | 16 +
 rtl/ram_b_ctrl.sv | 132 +++++++++++++
 tb/tb_ram_b_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_b_ctrl_pkg.sv
// Shared definitions for the ram_b_ctrl CPU-to-block-RAM bus controller.
// Holds the default geometry, the full byte-enable constant and the FSM state encoding.
package ram_b_ctrl_pkg;

  localparam int unsigned DEPTH_DEF  = 128;
  localparam int unsigned RAM_AW_DEF = 20;
  localparam int unsigned DW_DEF     = 32;
  localparam logic [3:0]  BE_FULL    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RMW_RD,
    ST_RMW_MERGE,
    ST_WR
  } state_t;

endpackage

// File: rtl/ram_b_ctrl_be_merge.sv
// Byte-enable merge: each output byte comes from the new word when its enable is set,
// otherwise from the old word. Purely combinational; usable by any byte-addressable memory.
module be_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   i_old,
  input  logic [DW-1:0]   i_new,
  input  logic [DW/8-1:0] i_be,
  output logic [DW-1:0]   o_merged
);

  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_byte
    assign o_merged[8*gi +: 8] = i_be[gi] ? i_new[8*gi +: 8] : i_old[8*gi +: 8];
  end

endmodule

// File: rtl/ram_b_ctrl.sv
// CPU-side controller for a 1-cycle-latency block RAM: reads, full writes, read-modify-write
// for partial writes, and a bus error for word addresses beyond DEPTH.
module ram_b_ctrl
  import ram_b_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned RAM_AW = RAM_AW_DEF,
  parameter int unsigned DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              resp_valid,
  output logic [DW-1:0]     resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_din,
  input  logic [47:0]       ram_dout
);

  state_t              r_state;
  state_t              w_next_state;
  logic [RAM_AW-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [DW-1:0]       r_din;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [DW-1:0]       r_resp_rdata;
  logic                w_idle;
  logic                w_wr;
  logic                w_resp_next;
  logic                w_err_next;
  logic                w_addr_err;
  logic                w_accept;
  logic [DW-1:0]       w_merged;
  logic                w_unused;

  // The range check uses the whole 30-bit word address so high addresses cannot alias.
  assign w_addr_err = {2'b00, req_addr[31:2]} >= DEPTH;
  assign w_accept   = req_valid & w_idle;
  assign w_unused   = ^{req_addr[1:0], ram_dout[47:DW]};

  be_merge #(.DW(DW)) u_be_merge (
    .i_old    (ram_dout[DW-1:0]),
    .i_new    (r_din),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_idle       = 1'b0;
    w_wr         = 1'b0;
    w_resp_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        if (req_valid) begin
          if (w_addr_err) begin
            w_resp_next = 1'b1;
            w_err_next  = 1'b1;
          end else if (!req_we) begin
            w_next_state = ST_RD;
          end else if (req_be == 4'h0) begin
            w_resp_next = 1'b1;
          end else if (req_be == BE_FULL) begin
            w_next_state = ST_WR;
          end else begin
            w_next_state = ST_RMW_RD;
          end
        end
      end
      ST_RD:        w_next_state = ST_RD_WAIT;
      ST_RD_WAIT: begin
        w_next_state = ST_IDLE;
        w_resp_next  = 1'b1;
      end
      ST_RMW_RD:    w_next_state = ST_RMW_MERGE;
      ST_RMW_MERGE: w_next_state = ST_WR;
      ST_WR: begin
        w_wr         = 1'b1;
        w_next_state = ST_IDLE;
        w_resp_next  = 1'b1;
      end
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_be         <= '0;
      r_din        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next_state;
      r_resp_valid <= w_resp_next;
      r_resp_err   <= w_err_next;
      // Read data is only sampled in RD_WAIT, never in the cycle after a write.
      r_resp_rdata <= (r_state == ST_RD_WAIT) ? ram_dout[DW-1:0] : '0;
      if (w_accept && !w_addr_err) begin
        r_addr <= req_addr[RAM_AW+1:2];
        r_be   <= req_be;
        r_din  <= req_wdata;
      end else if (r_state == ST_RMW_MERGE) begin
        r_din  <= w_merged;
      end
    end
  end

  // Gating with rst keeps the RAM from being written and requests from being taken during reset.
  assign req_ready  = w_idle & ~rst;
  assign ram_we     = w_wr & ~rst;
  assign ram_addr   = r_addr;
  assign ram_din    = r_din;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_ram_b_ctrl.sv
// Scoreboard bench for ram_b_ctrl: stimulus pushes expected responses and RAM writes into
// queues; a negedge monitor pops and compares them whenever the DUT presents one.
module tb_ram_b_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [19:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [47:0] ram_dout;

  ram_b_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // 128x32 RAM model, 1-cycle read latency, junk upper bits, high-Z after a write.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[6:0]] <= ram_din;
      ram_dout           <= 'z;
    end else begin
      ram_dout <= {16'hBEEF, mem[ram_addr[6:0]]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int cyc; logic [19:0] addr; logic [31:0] data; } wr_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every response pulse and every RAM write against the queues.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) flag("resp_unexpected");
      else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        check("resp_err",   64'(resp_err),   64'(e.err));
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) flag("ram_we_unexpected");
      else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_cycle", 64'(cyc),      64'(w.cyc));
        check("wr_addr",  64'(ram_addr), 64'(w.addr));
        check("wr_data",  64'(ram_din),  64'(w.data));
      end
    end
  end

  // Issue one request; when track is set, push the expected response (and write if wr_lat>=0).
  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lat, input logic [31:0] exp_rdata,
                      input logic exp_err, input int wr_lat, input logic [31:0] wr_data,
                      input bit track, output int t_acc);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    if (!ok) begin
      flag("accept_timeout");
      return;
    end
    if (track) begin
      exp_q.push_back('{cyc + lat, exp_rdata, exp_err});
      if (wr_lat >= 0) wr_q.push_back('{cyc + wr_lat, addr[21:2], wr_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, output int t);
    send(1'b0, 4'h0, addr, 32'h0, 3, exp, 1'b0, -1, 32'h0, 1'b1, t);
  endtask

  task automatic wr_full(input logic [31:0] addr, input logic [31:0] data, output int t);
    send(1'b1, 4'hF, addr, data, 2, 32'h0, 1'b0, 1, data, 1'b1, t);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, t1, t2, t3;

  initial begin
    // Reset held for 2 cycles: nothing accepted, no response, no write.
    repeat (2) begin
      @(negedge clk);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_req_ready",  64'(req_ready),  64'h0);
      check("rst_ram_we",     64'(ram_we),     64'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready),  64'h1);
    check("post_rst_rdata",     64'(resp_rdata), 64'h0);
    check("post_rst_err",       64'(resp_err),   64'h0);
    check("post_rst_ram_addr",  64'(ram_addr),   64'h0);
    check("post_rst_ram_din",   64'(ram_din),    64'h0);
    @(posedge clk);
    #1;

    // Full write then read of byte address 0x10 (word 4); last legal word 127.
    wr_full(32'h10, 32'hDEADBEEF, t0);
    idle(2);
    rd(32'h10, 32'hDEADBEEF, t0);
    wr_full(32'h1FC, 32'hCAFE0127, t0);
    idle(3);

    // Partial write be=0101 over 0x11223344 -> 0x11BB33DD, write at T+3, resp at T+4.
    wr_full(32'h10, 32'h11223344, t0);
    send(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, 4, 32'h0, 1'b0, 3, 32'h11BB33DD, 1'b1, t1);
    check("rmw_accept_b2b", 64'(t1), 64'(t0 + 2));
    rd(32'h10, 32'h11BB33DD, t0);
    idle(4);

    // Out-of-range requests: error at T+1, rdata 0, RAM untouched; be=0 write is a no-op.
    send(1'b0, 4'h0, 32'h200, 32'h0, 1, 32'h0, 1'b1, -1, 32'h0, 1'b1, t0);
    send(1'b1, 4'hF, 32'h3FC, 32'h12345678, 1, 32'h0, 1'b1, -1, 32'h0, 1'b1, t0);
    send(1'b1, 4'hF, 32'h8000_0010, 32'h0BADF00D, 1, 32'h0, 1'b1, -1, 32'h0, 1'b1, t0);
    send(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1'b0, -1, 32'h0, 1'b1, t0);
    rd(32'h1FC, 32'hCAFE0127, t0);
    rd(32'h10, 32'h11BB33DD, t0);
    idle(4);

    // Back-to-back with req_valid held: read, read, write, read.
    rd(32'h10, 32'h11BB33DD, t0);
    rd(32'h1FC, 32'hCAFE0127, t1);
    wr_full(32'h20, 32'h55AA55AA, t2);
    rd(32'h20, 32'h55AA55AA, t3);
    check("b2b_accept_rd2", 64'(t1), 64'(t0 + 3));
    check("b2b_accept_wr",  64'(t2), 64'(t1 + 3));
    check("b2b_accept_rd3", 64'(t3), 64'(t2 + 2));
    idle(4);

    // Reset in the RMW_MERGE cycle: request dropped, no write, no response.
    send(1'b1, 4'b0011, 32'h10, 32'h99999999, 0, 32'h0, 1'b0, -1, 32'h0, 1'b0, t0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_merge_ram_we", 64'(ram_we), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_merge_idle",       64'(req_ready),  64'h1);
    check("rst_merge_resp_valid", 64'(resp_valid), 64'h0);
    @(posedge clk);
    #1;
    rd(32'h10, 32'h11BB33DD, t0);

    // Reset in the WR cycle of a full write: the write is suppressed.
    send(1'b1, 4'hF, 32'h20, 32'h77777777, 0, 32'h0, 1'b0, -1, 32'h0, 1'b0, t0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_wr_ram_we", 64'(ram_we), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(32'h20, 32'h55AA55AA, t0);
    idle(2);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("resp_queue_drained", 64'(exp_q.size()), 64'h0);
    check("wr_queue_drained",   64'(wr_q.size()),  64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
